// File: rtl/uart_rx_fifo_pkg.sv
`timescale 1ns/1ps
// Shared FSM states, status bit positions and baud divider helper for uart_rx_fifo.
package uart_rx_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT
  } rx_state_e;

  localparam int STAT_READY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_FRAME_ERR = 3;

  localparam logic [3:0] MID_SAMPLE  = 4'd7;
  localparam logic [3:0] LAST_SAMPLE = 4'd15;

  // Rounded clocks per 16x oversample tick.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + 8 * baud) / (16 * baud);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
`timescale 1ns/1ps
// Generic synchronous FIFO; dout shows the head combinationally, count updates the clk after push/pop.
// Push when full is dropped unless a pop happens in the same clk; pop when empty is ignored.
module uart_rx_fifo_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A pop in the same clk frees the head slot, so a full FIFO still takes the push.
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// 16x-oversampled 8N1 UART receiver feeding a byte FIFO; ready rises ~9.5 bit times after the start edge.
// No backpressure on the line: a byte arriving at a full FIFO without a same-clk pop is dropped and flags overrun.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16
) (
  input  logic       clk,
  input  logic       res,
  input  logic       rx,
  input  logic       rd_req,
  input  logic       clr_req,
  output logic [7:0] data_out,
  output logic [7:0] status,
  output logic       irq
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int DW  = $clog2(DIV + 1);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic            rx_meta_q, rx_meta_d;
  logic            rxs_q, rxs_d;
  logic            rxs_prev_q, rxs_prev_d;
  logic            rd_prev_q, rd_prev_d;
  logic            clr_prev_q, clr_prev_d;
  rx_state_e       state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [3:0]      smp_q, smp_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            overrun_q, overrun_d;
  logic            frame_err_q, frame_err_d;

  logic            tick, push, pop, pop_eff, frame_evt, ovf_evt, clr_rise, ready, full;
  logic [7:0]      fifo_dout;
  logic [CW-1:0]   fifo_count;

  uart_rx_fifo_sync_fifo #(
    .W     (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .res   (res),
    .push  (push),
    .pop   (pop),
    .din   (shreg_q),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  always_comb begin
    rx_meta_d  = rx;
    rxs_d      = rx_meta_q;
    rxs_prev_d = rxs_q;
    rd_prev_d  = rd_req;
    clr_prev_d = clr_req;

    tick      = (div_q == DIV_LAST);
    div_d     = tick ? '0 : div_q + 1'b1;
    state_d   = state_q;
    smp_d     = smp_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    push      = 1'b0;
    frame_evt = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Zeroing the divider here phases every sample relative to the start edge.
        if (rxs_prev_q && !rxs_q) begin
          state_d = ST_START;
          smp_d   = '0;
          div_d   = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (smp_q == MID_SAMPLE) begin
            if (rxs_q) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DATA;
              smp_d   = '0;
              bit_d   = '0;
            end
          end else begin
            smp_d = smp_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (smp_q == LAST_SAMPLE) begin
            shreg_d = {rxs_q, shreg_q[7:1]};
            smp_d   = '0;
            bit_d   = bit_q + 1'b1;
            if (bit_q == 3'd7) begin
              state_d = ST_STOP;
            end
          end else begin
            smp_d = smp_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (smp_q == LAST_SAMPLE) begin
            if (rxs_q) begin
              push    = 1'b1;
              state_d = ST_IDLE;
            end else begin
              frame_evt = 1'b1;
              state_d   = ST_WAIT;
            end
          end else begin
            smp_d = smp_q + 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (tick && rxs_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pop at the end of the CPU read so data_out holds for the whole access.
    pop      = rd_prev_q && !rd_req;
    pop_eff  = pop && (fifo_count != '0);
    full     = (fifo_count == FULL_CNT);
    ready    = (fifo_count != '0);
    ovf_evt  = push && full && !pop_eff;
    clr_rise = clr_req && !clr_prev_q;

    overrun_d   = ovf_evt   ? 1'b1 : (clr_rise ? 1'b0 : overrun_q);
    frame_err_d = frame_evt ? 1'b1 : (clr_rise ? 1'b0 : frame_err_q);

    status                 = 8'h00;
    status[STAT_READY]     = ready;
    status[STAT_FULL]      = full;
    status[STAT_OVERRUN]   = overrun_q;
    status[STAT_FRAME_ERR] = frame_err_q;
    data_out               = ready ? fifo_dout : 8'hFF;
    irq                    = ready;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      rxs_prev_q  <= 1'b1;
      rd_prev_q   <= 1'b0;
      clr_prev_q  <= 1'b0;
      state_q     <= ST_IDLE;
      div_q       <= '0;
      smp_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rxs_q       <= rxs_d;
      rxs_prev_q  <= rxs_prev_d;
      rd_prev_q   <= rd_prev_d;
      clr_prev_q  <= clr_prev_d;
      state_q     <= state_d;
      div_q       <= div_d;
      smp_q       <= smp_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
// Directed self-checking bench for uart_rx_fifo at a fast line rate (DIV = 6, 96 clks per bit).
module tb_uart_rx_fifo;

  localparam int TB_CLK   = 50_000_000;
  localparam int TB_BAUD  = 520_833;
  localparam int BIT_CLKS = 96;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       rx = 1'b1;
  logic       rd_req = 1'b0;
  logic       clr_req = 1'b0;
  logic [7:0] data_out;
  logic [7:0] status;
  logic       irq;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int seen_rdy = 0;
  int rdy_cyc = 0;
  int lat = 912;
  logic [7:0] d;

  uart_rx_fifo #(
    .CLK_HZ (TB_CLK),
    .BAUD   (TB_BAUD),
    .DEPTH  (16)
  ) dut (
    .clk      (clk),
    .res      (res),
    .rx       (rx),
    .rd_req   (rd_req),
    .clr_req  (clr_req),
    .data_out (data_out),
    .status   (status),
    .irq      (irq)
  );

  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Clock-aligned 8N1 frame; cyc counts posedges since the start edge was driven.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int pop_at, input int nbits);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    cyc = 0;
    seen_rdy = 0;
    if (pop_at >= 0) rd_req = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      rx = fr[i];
      for (int k = 0; k < BIT_CLKS; k++) begin
        step();
        if (cyc == pop_at) rd_req = 1'b0;
        if (seen_rdy == 0 && status[0] === 1'b1) begin
          seen_rdy = 1;
          rdy_cyc = cyc;
        end
      end
    end
    if (stop_ok) rx = 1'b1;
  endtask

  task automatic read_byte(output logic [7:0] v);
    rd_req = 1'b1;
    step();
    step();
    v = data_out;
    step();
    rd_req = 1'b0;
    step();
    step();
  endtask

  task automatic pulse_clr();
    clr_req = 1'b1;
    step();
    step();
    clr_req = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    res = 1'b1;
    rx = 1'b1;
    idle(4);
    res = 1'b0;
    idle(3);
    checks++; if (status !== 8'h00) begin failures++; $display("FAIL reset_status got=%02h exp=00", status); end
    checks++; if (data_out !== 8'hFF) begin failures++; $display("FAIL reset_data got=%02h exp=FF", data_out); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%0b exp=0", irq); end
  endtask

  task automatic test_single_byte();
    send_frame(8'h55, 1'b1, -1, 10);
    checks++;
    if (seen_rdy == 0) begin
      failures++;
      $display("FAIL single_latency got=none exp=900..930");
    end else begin
      lat = rdy_cyc;
      if (rdy_cyc < 900 || rdy_cyc > 930) begin
        failures++;
        $display("FAIL single_latency got=%0d exp=900..930", rdy_cyc);
      end
    end
    idle(2);
    checks++; if (status !== 8'h01) begin failures++; $display("FAIL single_status got=%02h exp=01", status); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL single_irq got=%0b exp=1", irq); end
    checks++; if (data_out !== 8'h55) begin failures++; $display("FAIL single_data got=%02h exp=55", data_out); end
    read_byte(d);
    checks++; if (d !== 8'h55) begin failures++; $display("FAIL single_read got=%02h exp=55", d); end
    checks++; if (data_out !== 8'hFF) begin failures++; $display("FAIL single_empty_data got=%02h exp=FF", data_out); end
    checks++; if (status !== 8'h00) begin failures++; $display("FAIL single_empty_status got=%02h exp=00", status); end
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    idle(20);
    rx = 1'b1;
    idle(2 * BIT_CLKS);
    checks++; if (status !== 8'h00) begin failures++; $display("FAIL glitch_status got=%02h exp=00", status); end
    checks++; if (data_out !== 8'hFF) begin failures++; $display("FAIL glitch_data got=%02h exp=FF", data_out); end
    send_frame(8'h3A, 1'b1, -1, 10);
    idle(2);
    checks++; if (data_out !== 8'h3A) begin failures++; $display("FAIL glitch_next_data got=%02h exp=3A", data_out); end
    read_byte(d);
    checks++; if (status !== 8'h00) begin failures++; $display("FAIL glitch_next_status got=%02h exp=00", status); end
  endtask

  task automatic test_frame_error();
    send_frame(8'hA5, 1'b0, -1, 10);
    idle(25 * BIT_CLKS);
    rx = 1'b1;
    idle(2 * BIT_CLKS);
    checks++; if (status !== 8'h08) begin failures++; $display("FAIL ferr_status got=%02h exp=08", status); end
    checks++; if (data_out !== 8'hFF) begin failures++; $display("FAIL ferr_data got=%02h exp=FF", data_out); end
    send_frame(8'h5A, 1'b1, -1, 10);
    idle(2);
    checks++; if (status !== 8'h09) begin failures++; $display("FAIL ferr_next_status got=%02h exp=09", status); end
    checks++; if (data_out !== 8'h5A) begin failures++; $display("FAIL ferr_next_data got=%02h exp=5A", data_out); end
    read_byte(d);
    checks++; if (status !== 8'h08) begin failures++; $display("FAIL ferr_sticky got=%02h exp=08", status); end
    pulse_clr();
    checks++; if (status !== 8'h00) begin failures++; $display("FAIL ferr_clear got=%02h exp=00", status); end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, -1, 10);
    idle(2);
    checks++; if (status !== 8'h07) begin failures++; $display("FAIL ovr_status got=%02h exp=07", status); end
    for (int i = 0; i < 16; i++) begin
      read_byte(d);
      checks++; if (d !== 8'(i)) begin failures++; $display("FAIL ovr_read%0d got=%02h exp=%02h", i, d, 8'(i)); end
    end
    checks++; if (data_out !== 8'hFF) begin failures++; $display("FAIL ovr_empty_data got=%02h exp=FF", data_out); end
    checks++; if (status !== 8'h04) begin failures++; $display("FAIL ovr_empty_status got=%02h exp=04", status); end
    pulse_clr();
    checks++; if (status !== 8'h00) begin failures++; $display("FAIL ovr_clear got=%02h exp=00", status); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b1, -1, 10);
    idle(2);
    checks++; if (status !== 8'h03) begin failures++; $display("FAIL pp_full_status got=%02h exp=03", status); end
    // Release rd_req so its falling edge lands in the push clk (one clk before ready would rise).
    send_frame(8'h30, 1'b1, lat - 1, 10);
    idle(2);
    checks++; if (status !== 8'h03) begin failures++; $display("FAIL pp_status got=%02h exp=03", status); end
    for (int i = 0; i < 16; i++) begin
      read_byte(d);
      checks++; if (d !== 8'h21 + 8'(i)) begin failures++; $display("FAIL pp_read%0d got=%02h exp=%02h", i, d, 8'h21 + 8'(i)); end
    end
    checks++; if (data_out !== 8'hFF) begin failures++; $display("FAIL pp_empty_data got=%02h exp=FF", data_out); end
    checks++; if (status !== 8'h00) begin failures++; $display("FAIL pp_empty_status got=%02h exp=00", status); end
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'h11, 1'b1, -1, 10);
    idle(2);
    checks++; if (status !== 8'h01) begin failures++; $display("FAIL rst_pre_status got=%02h exp=01", status); end
    send_frame(8'h3C, 1'b1, -1, 4);
    res = 1'b1;
    idle(2);
    rx = 1'b1;
    idle(1);
    res = 1'b0;
    idle(2 * BIT_CLKS);
    checks++; if (status !== 8'h00) begin failures++; $display("FAIL rst_status got=%02h exp=00", status); end
    checks++; if (data_out !== 8'hFF) begin failures++; $display("FAIL rst_data got=%02h exp=FF", data_out); end
    send_frame(8'h81, 1'b1, -1, 10);
    idle(2);
    checks++; if (status !== 8'h01) begin failures++; $display("FAIL rst_next_status got=%02h exp=01", status); end
    read_byte(d);
    checks++; if (d !== 8'h81) begin failures++; $display("FAIL rst_next_read got=%02h exp=81", d); end
    checks++; if (status !== 8'h00) begin failures++; $display("FAIL rst_final_status got=%02h exp=00", status); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_full_push_pop();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
